// File: rtl/guesser_core.sv
// guesser_core: hidden-gate guessing game core.
// Holds one of eight bitwise two-input functions, picked from a free-running
// 8-bit LFSR when a round starts. It answers a bounded number of probes, then
// scores a single guess. Every register freezes while ena is low.
module guesser_core #(
    parameter int         WIDTH      = 4,
    parameter int         MAX_PROBES = 4,
    parameter int         SCORE_W    = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               probe_valid,
    input  logic [WIDTH-1:0]   probe_a,
    input  logic [WIDTH-1:0]   probe_b,
    input  logic               guess_valid,
    input  logic [2:0]         guess_gate,
    output logic [WIDTH-1:0]   probe_result,
    output logic               probe_err,
    output logic [3:0]         probes_left,
    output logic [1:0]         state,
    output logic               correct,
    output logic [2:0]         reveal,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] rounds
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROBE  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_lfsr;
    logic [7:0]         w_lfsr_next;
    logic [2:0]         r_hidden;
    logic [WIDTH-1:0]   r_probe_result;
    logic [WIDTH-1:0]   w_func;
    logic               r_probe_err;
    logic [3:0]         r_probes_left;
    logic               r_correct;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_rounds;

    logic               w_do_start;
    logic               w_do_probe;
    logic               w_do_reject;
    logic               w_do_guess;
    logic               w_guess_hit;

    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_guess_hit = (guess_gate == r_hidden);

    // Hidden function evaluated bit by bit on the current probe operands
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_func
        always_comb begin
            w_func[gi] = 1'b0;
            case (r_hidden)
                3'd0:    w_func[gi] =   probe_a[gi] &  probe_b[gi];
                3'd1:    w_func[gi] =   probe_a[gi] |  probe_b[gi];
                3'd2:    w_func[gi] =   probe_a[gi] ^  probe_b[gi];
                3'd3:    w_func[gi] = ~(probe_a[gi] &  probe_b[gi]);
                3'd4:    w_func[gi] = ~(probe_a[gi] |  probe_b[gi]);
                3'd5:    w_func[gi] = ~(probe_a[gi] ^  probe_b[gi]);
                3'd6:    w_func[gi] =   probe_a[gi] & ~probe_b[gi];
                default: w_func[gi] =   probe_a[gi] | ~probe_b[gi];
            endcase
        end
    end

    // Next state and one-hot action strobes; a guess beats a probe in the same cycle
    always_comb begin
        w_state_next = r_state;
        w_do_start   = 1'b0;
        w_do_probe   = 1'b0;
        w_do_reject  = 1'b0;
        w_do_guess   = 1'b0;
        case (r_state)
            S_IDLE, S_RESULT: begin
                if (start) begin
                    w_do_start   = 1'b1;
                    w_state_next = S_PROBE;
                end
            end
            S_PROBE: begin
                if (guess_valid) begin
                    w_do_guess   = 1'b1;
                    w_state_next = S_RESULT;
                end else if (probe_valid) begin
                    if (r_probes_left != 4'd0) begin
                        w_do_probe = 1'b1;
                    end else begin
                        w_do_reject = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    // Free-running LFSR, hidden code capture and probe-error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= LFSR_SEED;
            r_hidden    <= 3'd0;
            r_probe_err <= 1'b0;
        end else if (ena) begin
            r_lfsr      <= w_lfsr_next;
            r_probe_err <= w_do_reject;
            if (w_do_start) begin
                r_hidden <= r_lfsr[2:0];
            end
        end
    end

    // Probe datapath: result register and remaining-probe budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_probe_result <= '0;
            r_probes_left  <= 4'd0;
        end else if (ena) begin
            if (w_do_start) begin
                r_probe_result <= '0;
                r_probes_left  <= 4'(MAX_PROBES);
            end else if (w_do_probe) begin
                r_probe_result <= w_func;
                r_probes_left  <= r_probes_left - 4'd1;
            end
        end
    end

    // Guess scoring with saturating score and round counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_correct <= 1'b0;
            r_score   <= '0;
            r_rounds  <= '0;
        end else if (ena) begin
            if (w_do_start) begin
                r_correct <= 1'b0;
            end else if (w_do_guess) begin
                r_correct <= w_guess_hit;
                if (w_guess_hit && (r_score != {SCORE_W{1'b1}})) begin
                    r_score <= r_score + 1'b1;
                end
                if (r_rounds != {SCORE_W{1'b1}}) begin
                    r_rounds <= r_rounds + 1'b1;
                end
            end
        end
    end

    assign probe_result = r_probe_result;
    assign probe_err    = r_probe_err;
    assign probes_left  = r_probes_left;
    assign state        = r_state;
    assign correct      = r_correct;
    assign reveal       = (r_state == S_RESULT) ? r_hidden : 3'd0;
    assign score        = r_score;
    assign rounds       = r_rounds;

endmodule

// File: tb/tb_guesser_core.sv
// Testbench for guesser_core: directed scenarios plus a random phase, checked
// against a game-level reference model. Two instances share stimulus; one has
// 2-bit counters so saturation is reachable in a few rounds.
module tb_guesser_core;

    localparam int W  = 4;
    localparam int MP = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic         start = 1'b0;
    logic         probe_valid = 1'b0;
    logic [W-1:0] probe_a = '0;
    logic [W-1:0] probe_b = '0;
    logic         guess_valid = 1'b0;
    logic [2:0]   guess_gate = 3'd0;

    logic [W-1:0] d8_probe_result, d2_probe_result;
    logic         d8_probe_err, d2_probe_err;
    logic [3:0]   d8_probes_left, d2_probes_left;
    logic [1:0]   d8_state, d2_state;
    logic         d8_correct, d2_correct;
    logic [2:0]   d8_reveal, d2_reveal;
    logic [7:0]   d8_score, d8_rounds;
    logic [1:0]   d2_score, d2_rounds;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (game-level view)
    int           m_phase;   // 0 idle, 1 probing, 2 result
    logic [7:0]   m_lfsr;
    int           m_hidden;
    int           m_left;
    int           m_score;
    int           m_rounds;
    logic [W-1:0] m_res;
    bit           m_err;
    bit           m_correct;

    guesser_core #(.WIDTH(W), .MAX_PROBES(MP), .SCORE_W(8), .LFSR_SEED(8'hA5)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .probe_valid(probe_valid), .probe_a(probe_a), .probe_b(probe_b),
        .guess_valid(guess_valid), .guess_gate(guess_gate),
        .probe_result(d8_probe_result), .probe_err(d8_probe_err),
        .probes_left(d8_probes_left), .state(d8_state), .correct(d8_correct),
        .reveal(d8_reveal), .score(d8_score), .rounds(d8_rounds)
    );

    guesser_core #(.WIDTH(W), .MAX_PROBES(MP), .SCORE_W(2), .LFSR_SEED(8'hA5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .probe_valid(probe_valid), .probe_a(probe_a), .probe_b(probe_b),
        .guess_valid(guess_valid), .guess_gate(guess_gate),
        .probe_result(d2_probe_result), .probe_err(d2_probe_err),
        .probes_left(d2_probes_left), .state(d2_state), .correct(d2_correct),
        .reveal(d2_reveal), .score(d2_score), .rounds(d2_rounds)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gate_f(input int code, input logic [W-1:0] a, input logic [W-1:0] b);
        case (code)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return ~(a ^ b);
            6: return a & ~b;
            default: return a | ~b;
        endcase
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_lfsr = 8'hA5; m_hidden = 0; m_left = 0;
        m_score = 0; m_rounds = 0; m_res = '0; m_err = 0; m_correct = 0;
    endtask

    // One enabled clock of the game rules
    task automatic model_step(input logic st, input logic pv, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic gv, input logic [2:0] g);
        m_err = 0;
        if (st && m_phase != 1) begin
            m_hidden  = int'(m_lfsr % 8);
            m_left    = MP;
            m_correct = 0;
            m_res     = '0;
            m_phase   = 1;
        end else if (m_phase == 1) begin
            if (gv) begin
                m_correct = (int'(g) == m_hidden);
                if (m_correct) m_score++;
                m_rounds++;
                m_phase = 2;
            end else if (pv) begin
                if (m_left > 0) begin
                    m_res = gate_f(m_hidden, a, b);
                    m_left--;
                end else begin
                    m_err = 1;
                end
            end
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int exp_reveal;
        exp_reveal = (m_phase == 2) ? m_hidden : 0;
        chk("state8", 32'(d8_state), 32'(m_phase));
        chk("state2", 32'(d2_state), 32'(m_phase));
        chk("result8", 32'(d8_probe_result), 32'(m_res));
        chk("result2", 32'(d2_probe_result), 32'(m_res));
        chk("err8", 32'(d8_probe_err), 32'(m_err));
        chk("err2", 32'(d2_probe_err), 32'(m_err));
        chk("left8", 32'(d8_probes_left), 32'(m_left));
        chk("left2", 32'(d2_probes_left), 32'(m_left));
        chk("correct8", 32'(d8_correct), 32'(m_correct));
        chk("correct2", 32'(d2_correct), 32'(m_correct));
        chk("reveal8", 32'(d8_reveal), 32'(exp_reveal));
        chk("reveal2", 32'(d2_reveal), 32'(exp_reveal));
        chk("score8", 32'(d8_score), 32'(sat(m_score, 255)));
        chk("score2", 32'(d2_score), 32'(sat(m_score, 3)));
        chk("rounds8", 32'(d8_rounds), 32'(sat(m_rounds, 255)));
        chk("rounds2", 32'(d2_rounds), 32'(sat(m_rounds, 3)));
    endtask

    // Drive one cycle of inputs, clock, advance the model, then compare
    task automatic step(input logic st, input logic pv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic gv, input logic [2:0] g,
                        input logic en);
        start = st; probe_valid = pv; probe_a = a; probe_b = b;
        guess_valid = gv; guess_gate = g; ena = en;
        @(posedge clk);
        if (rst_n && en) model_step(st, pv, a, b, gv, g);
        #1;
        $display("t=%0t st=%0b pv=%0b a=%h b=%h gv=%0b g=%0d en=%0b -> state=%0d res=%h err=%0b left=%0d cor=%0b rev=%0d score=%0d rounds=%0d",
                 $time, st, pv, a, b, gv, g, en, d8_state, d8_probe_result, d8_probe_err,
                 d8_probes_left, d8_correct, d8_reveal, d8_score, d8_rounds);
        check_all();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
    endtask

    initial begin
        // Reset state
        model_reset();
        ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Round 1: start on first enabled edge picks code 5 (XNOR)
        step(1'b1, 1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        chk("tp1_left_after_start", 32'(d8_probes_left), 32'd4);
        step(1'b0, 1'b1, 4'b1100, 4'b1010, 1'b0, 3'd0, 1'b1);
        chk("tp1_xnor_result", 32'(d8_probe_result), 32'b1001);
        chk("tp1_left", 32'(d8_probes_left), 32'd3);

        // Exhaust budget, then one rejected probe
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, 3'd0, 1'b1);
        chk("tp2_left_zero", 32'(d8_probes_left), 32'd0);
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 3'd0, 1'b1);
        chk("tp2_err_pulse", 32'(d8_probe_err), 32'd1);
        idle_step();
        chk("tp2_err_cleared", 32'(d8_probe_err), 32'd0);

        // Correct guess
        step(1'b0, 1'b0, '0, '0, 1'b1, 3'd5, 1'b1);
        chk("tp3_state", 32'(d8_state), 32'd2);
        chk("tp3_correct", 32'(d8_correct), 32'd1);
        chk("tp3_reveal", 32'(d8_reveal), 32'd5);
        chk("tp3_score", 32'(d8_score), 32'd1);
        chk("tp3_rounds", 32'(d8_rounds), 32'd1);

        // Round 2: wrong guess with a simultaneous probe
        step(1'b1, 1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b1, 4'h3, 4'h5, 1'b1, 3'((m_hidden + 1) % 8), 1'b1);
        chk("tp4_correct", 32'(d8_correct), 32'd0);
        chk("tp4_score", 32'(d8_score), 32'd1);
        chk("tp4_rounds", 32'(d8_rounds), 32'd2);
        chk("tp4_left", 32'(d8_probes_left), 32'(MP));

        // Probe/guess ignored in RESULT, start ignored mid-round
        step(1'b0, 1'b1, 4'h1, 4'h2, 1'b1, 3'd0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b1, 4'h6, 4'h9, 1'b0, 3'd0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        chk("start_ignored_left", 32'(d8_probes_left), 32'(MP - 1));

        // Freeze with ena low while inputs toggle
        for (int i = 0; i < 10; i++)
            step(1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                 1'($urandom), 3'($urandom), 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 3'(m_hidden), 1'b1);
        chk("tp5_correct", 32'(d8_correct), 32'd1);
        step(1'b1, 1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 3'd0, 1'b1);
        chk("tp5_next_hidden", 32'(d8_reveal), 32'(m_hidden));

        // Random play
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4), W'($urandom), W'($urandom),
                 ($urandom_range(0, 9) == 0), 3'($urandom), ($urandom_range(0, 9) != 0));

        // Asynchronous reset mid-round
        step(1'b1, 1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b1, 4'hA, 4'h5, 1'b0, 3'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(d8_state), 32'd0);
        chk("arst_left", 32'(d8_probes_left), 32'd0);
        chk("arst_result", 32'(d8_probe_result), 32'd0);
        chk("arst_score", 32'(d8_score), 32'd0);
        chk("arst_rounds", 32'(d8_rounds), 32'd0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Five winning rounds: 2-bit score saturates
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 1'b0, '0, '0, 1'b0, 3'd0, 1'b1);
            step(1'b0, 1'b0, '0, '0, 1'b1, 3'(m_hidden), 1'b1);
        end
        chk("tp6_score_sat", 32'(d2_score), 32'd3);
        chk("tp6_rounds_sat", 32'(d2_rounds), 32'd3);
        chk("tp6_score_wide", 32'(d8_score), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/guesser_core.md
Name: guesser_core

Overview:
Parametrised game core for the gate-guessing puzzle. It hides one of eight bitwise two-input logic functions, chosen pseudo-randomly. The player applies WIDTH-bit operand probes and sees the hidden function's result, then submits a guess. The core keeps a bounded probe budget, a saturating score and a round counter. It sits between the pad-level top wrapper, which maps ui_in/uio_in/uo_out, and the player I/O.

Parameters:
WIDTH, 4, operand and probe-result width in bits (1..8)
MAX_PROBES, 4, probes allowed per round (1..15)
SCORE_W, 8, width of score and round counters
LFSR_SEED, 8'hA5, reset value of the 8-bit LFSR; must be nonzero

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state including the LFSR
start  in  1  begin a round (pulse)
probe_valid  in  1  probe request
probe_a  in  WIDTH  probe operand A
probe_b  in  WIDTH  probe operand B
guess_valid  in  1  guess submission
guess_gate  in  3  guessed function code
probe_result  out  WIDTH  registered F(probe_a, probe_b)
probe_err  out  1  one-cycle pulse: probe rejected
probes_left  out  4  remaining probes this round
state  out  2  0=IDLE, 1=PROBE, 2=RESULT
correct  out  1  last guess matched; valid in RESULT
reveal  out  3  hidden code; driven only in RESULT, else 0
score  out  SCORE_W  correct guesses, saturating
rounds  out  SCORE_W  rounds completed, saturating

Behaviour:
- Reset (async assert, sync release): state=IDLE; probe_result, probe_err, probes_left, correct, reveal, score, rounds = 0; lfsr=LFSR_SEED.
- ena low: no register updates of any kind; inputs ignored; outputs hold.
- LFSR: 8-bit Fibonacci, next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Advances every enabled cycle in all states.
- Function codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 A&~B, 7 A|~B. Applied bitwise across WIDTH.
- start in IDLE or RESULT: hidden <= lfsr[2:0], using the current value before the update on that edge. Same edge: probes_left <= MAX_PROBES, correct <= 0, probe_result <= 0, state <= PROBE.
- start in PROBE is ignored, so a round cannot be restarted mid-round.
- PROBE, probe_valid, probes_left>0: probe_result <= F(probe_a, probe_b) on the next edge (1-cycle latency); probes_left decrements.
- PROBE, probe_valid, probes_left==0: probe_result holds; probe_err=1 for one cycle; no other change.
- PROBE, guess_valid: correct <= (guess_gate==hidden); score increments if correct, saturating at all-ones; rounds increments, saturating; state <= RESULT.
- guess_valid and probe_valid in the same cycle: the guess wins; the probe is ignored and probes_left is unchanged.
- probe_valid or guess_valid in IDLE or RESULT: ignored, with no probe_err.
- RESULT: reveal = hidden; outputs hold until start.
- probe_err is a registered output, cleared on every enabled cycle in which it is not set.

Test Plan:
1. Reset release, then start on the first enabled cycle → hidden=5 (A5[2:0], XNOR). Probe a=4'b1100, b=4'b1010 → probe_result=4'b1001 next cycle; probes_left goes 4→3.
2. Continue round 1 with four more probes → three are accepted (probes_left reaches 0); the fifth probe overall gives probe_err=1 for exactly one cycle and probe_result holds.
3. guess_gate=5 with guess_valid → state=RESULT, correct=1, reveal=5, score=1, rounds=1.
4. start again, then a wrong guess that asserts probe_valid in the same cycle → correct=0, score unchanged, rounds=2, probes_left unchanged at MAX_PROBES.
5. Hold ena=0 for 10 cycles mid-PROBE while toggling all inputs → no output or LFSR change; the next hidden code matches the reference LFSR model.
6. Assert rst_n=0 mid-PROBE → all outputs clear immediately, asynchronously. Set SCORE_W=2 and win 5 rounds → score saturates at 3.
